// File: rtl/autocat_victim_selector_pkg.sv
// Shared constants for the autocat victim selector slice.
// Default geometry and a sizing helper for the debounce counter.
package autocat_victim_selector_pkg;

    localparam int DEFAULT_NUM_WAY       = 4;
    localparam int DEFAULT_NUM_WAY_LOG2  = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    // Width of a counter that must reach stable_cycles-1; never below one bit.
    function automatic int count_width(input int stable_cycles);
        if (stable_cycles > 1) begin
            count_width = $clog2(stable_cycles);
        end else begin
            count_width = 1;
        end
    endfunction

endpackage

// File: rtl/autocat_victim_selector_if.sv
// Waymask suggestion, miss request and victim response signals between
// the miss handler / autocat side and the victim selector.
interface autocat_victim_selector_if
    import autocat_victim_selector_pkg::*;
#(
    parameter int NUM_WAY      = DEFAULT_NUM_WAY,
    parameter int NUM_WAY_LOG2 = DEFAULT_NUM_WAY_LOG2
);
    logic [NUM_WAY-1:0]      suggested_waymask_in;
    logic                    miss_valid_in;
    logic                    miss_ready_out;
    logic                    victim_valid_out;
    logic                    victim_ready_in;
    logic [NUM_WAY-1:0]      victim_way_out;
    logic [NUM_WAY_LOG2-1:0] victim_index_out;
    logic [NUM_WAY-1:0]      active_waymask_out;
    logic                    mask_update_pulse_out;

    modport slave (
        input  suggested_waymask_in,
        input  miss_valid_in,
        output miss_ready_out,
        output victim_valid_out,
        input  victim_ready_in,
        output victim_way_out,
        output victim_index_out,
        output active_waymask_out,
        output mask_update_pulse_out
    );

    modport master (
        output suggested_waymask_in,
        output miss_valid_in,
        input  miss_ready_out,
        input  victim_valid_out,
        output victim_ready_in,
        input  victim_way_out,
        input  victim_index_out,
        input  active_waymask_out,
        input  mask_update_pulse_out
    );

endinterface

// File: rtl/autocat_victim_selector_rotating_priority_picker.sv
// Combinational circular first-set-bit finder: searches mask starting at
// ptr+1 and wrapping, returning the winner as one-hot and binary index.
module rotating_priority_picker
    import autocat_victim_selector_pkg::*;
#(
    parameter int NUM_WAY      = DEFAULT_NUM_WAY,
    parameter int NUM_WAY_LOG2 = DEFAULT_NUM_WAY_LOG2
) (
    input  logic [NUM_WAY-1:0]      mask,
    input  logic [NUM_WAY_LOG2-1:0] ptr,
    output logic [NUM_WAY-1:0]      onehot,
    output logic [NUM_WAY_LOG2-1:0] index
);

    // Circular scan; ptr itself is visited last, so a single-bit mask always wins.
    always_comb begin : search
        logic found_v;
        int   idx_v;
        onehot  = {NUM_WAY{1'b0}};
        index   = {NUM_WAY_LOG2{1'b0}};
        found_v = 1'b0;
        idx_v   = 0;
        for (int k = 1; k <= NUM_WAY; k++) begin
            idx_v = (int'(ptr) + k) % NUM_WAY;
            if (!found_v && mask[idx_v]) begin
                found_v       = 1'b1;
                onehot[idx_v] = 1'b1;
                index         = idx_v[NUM_WAY_LOG2-1:0];
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/autocat_victim_selector.sv
// Enforces the autocat-suggested waymask on refills: debounces suggestions,
// adopts them when idle, and hands out round-robin victims from the active mask.
module autocat_victim_selector
    import autocat_victim_selector_pkg::*;
#(
    parameter int NUM_WAY       = DEFAULT_NUM_WAY,
    parameter int NUM_WAY_LOG2  = DEFAULT_NUM_WAY_LOG2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input logic                     clk_in,
    input logic                     reset_in,
    autocat_victim_selector_if.slave bus
);

    localparam int                CNT_W   = count_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_WAY_LOG2-1:0] PTR_RESET = NUM_WAY_LOG2'(NUM_WAY - 1);

    logic                    victim_valid_r;
    logic [NUM_WAY-1:0]      victim_way_r;
    logic [NUM_WAY_LOG2-1:0] victim_index_r;
    logic [NUM_WAY_LOG2-1:0] ptr_r;
    logic [NUM_WAY-1:0]      candidate_r;
    logic [CNT_W-1:0]        count_r;
    logic [NUM_WAY-1:0]      active_r;
    logic                    pulse_r;

    logic                    miss_ready_s;
    logic                    accept_s;
    logic                    adopt_s;
    logic [NUM_WAY-1:0]      pick_way_s;
    logic [NUM_WAY_LOG2-1:0] pick_index_s;

    rotating_priority_picker #(
        .NUM_WAY      (NUM_WAY),
        .NUM_WAY_LOG2 (NUM_WAY_LOG2)
    ) u_picker (
        .mask   (active_r),
        .ptr    (ptr_r),
        .onehot (pick_way_s),
        .index  (pick_index_s)
    );

    assign miss_ready_s = ~victim_valid_r | bus.victim_ready_in;
    assign accept_s     = bus.miss_valid_in & miss_ready_s;

    // Adoption is blocked while a victim is pending or being accepted, so every
    // in-flight victim was drawn from a single mask.
    assign adopt_s = (count_r == CNT_MAX)
                   & (candidate_r != active_r)
                   & (candidate_r != {NUM_WAY{1'b0}})
                   & ~victim_valid_r
                   & ~accept_s;

    // Single-entry victim output register and round-robin pointer.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            victim_valid_r <= 1'b0;
            victim_way_r   <= {NUM_WAY{1'b0}};
            victim_index_r <= {NUM_WAY_LOG2{1'b0}};
            ptr_r          <= PTR_RESET;
        end else if (accept_s) begin
            victim_valid_r <= 1'b1;
            victim_way_r   <= pick_way_s;
            victim_index_r <= pick_index_s;
            ptr_r          <= pick_index_s;
        end else if (bus.victim_ready_in) begin
            victim_valid_r <= 1'b0;
        end
    end

    // Suggestion debounce: restart on any change, saturate once stable.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            candidate_r <= {NUM_WAY{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else if (bus.suggested_waymask_in != candidate_r) begin
            candidate_r <= bus.suggested_waymask_in;
            count_r     <= {CNT_W{1'b0}};
        end else if (count_r != CNT_MAX) begin
            count_r     <= count_r + CNT_W'(1);
        end
    end

    // Active mask and its one-cycle update pulse.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            active_r <= {NUM_WAY{1'b1}};
            pulse_r  <= 1'b0;
        end else begin
            pulse_r <= adopt_s;
            if (adopt_s) begin
                active_r <= candidate_r;
            end
        end
    end

    assign bus.miss_ready_out        = miss_ready_s;
    assign bus.victim_valid_out      = victim_valid_r;
    assign bus.victim_way_out        = victim_way_r;
    assign bus.victim_index_out      = victim_index_r;
    assign bus.active_waymask_out    = active_r;
    assign bus.mask_update_pulse_out = pulse_r;

endmodule

// File: tb/tb_autocat_victim_selector.sv
// Directed bench for autocat_victim_selector (NUM_WAY=4, STABLE_CYCLES=4)
// with hand-computed victim sequences and mask adoption timing.
module tb_autocat_victim_selector;

    int   checks   = 0;
    int   failures = 0;
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    int   pulses;

    always #5 clk = ~clk;

    autocat_victim_selector_if #(.NUM_WAY(4), .NUM_WAY_LOG2(2)) bus ();

    autocat_victim_selector #(
        .NUM_WAY       (4),
        .NUM_WAY_LOG2  (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_count(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.mask_update_pulse_out === 1'b1) p++;
        end
    endtask

    // Present a miss for one cycle and check the victim registered at the edge.
    task automatic miss_one(input string tag, input int idx);
        logic [3:0] exp_way;
        exp_way = 4'b0001 << idx;
        bus.miss_valid_in = 1'b1;
        tick();
        check_eq({tag, "_valid"}, 32'(bus.victim_valid_out), 32'd1);
        check_eq({tag, "_way"},   32'(bus.victim_way_out),   32'(exp_way));
        check_eq({tag, "_index"}, 32'(bus.victim_index_out), 32'(idx));
    endtask

    initial begin
        bus.suggested_waymask_in = 4'b1111;
        bus.miss_valid_in        = 1'b0;
        bus.victim_ready_in      = 1'b1;
        tick(); tick(); tick();
        check_eq("rst_valid",  32'(bus.victim_valid_out),      32'd0);
        check_eq("rst_way",    32'(bus.victim_way_out),        32'd0);
        check_eq("rst_index",  32'(bus.victim_index_out),      32'd0);
        check_eq("rst_active", 32'(bus.active_waymask_out),    32'hf);
        check_eq("rst_pulse",  32'(bus.mask_update_pulse_out), 32'd0);
        check_eq("rst_ready",  32'(bus.miss_ready_out),        32'd1);
        rst_n = 1'b1;
        tick();

        // Back-to-back misses with full mask: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            miss_one("b2b", i % 4);
            check_eq("b2b_ready", 32'(bus.miss_ready_out), 32'd1);
        end
        // Walk pointer to 3 so the 0101 mask starts from way 0
        for (int i = 1; i < 4; i++) miss_one("walk", i);
        bus.miss_valid_in = 1'b0;
        tick();
        check_eq("drain_valid", 32'(bus.victim_valid_out), 32'd0);

        // Adopt 0101
        bus.suggested_waymask_in = 4'b0101;
        idle_count(10, pulses);
        check_eq("m0101_pulses", 32'(pulses), 32'd1);
        check_eq("m0101_active", 32'(bus.active_waymask_out), 32'h5);
        miss_one("m0101_a", 0);
        miss_one("m0101_b", 2);
        miss_one("m0101_c", 0);
        miss_one("m0101_d", 2);
        bus.miss_valid_in = 1'b0;
        tick();

        // Backpressure holds victim and defers adoption of 0011
        bus.victim_ready_in = 1'b0;
        miss_one("bp", 0);
        bus.miss_valid_in = 1'b0;
        #1;
        check_eq("bp_ready", 32'(bus.miss_ready_out), 32'd0);
        bus.suggested_waymask_in = 4'b0011;
        idle_count(8, pulses);
        check_eq("bp_pulses", 32'(pulses), 32'd0);
        check_eq("bp_active", 32'(bus.active_waymask_out), 32'h5);
        check_eq("bp_way",    32'(bus.victim_way_out),     32'h1);
        check_eq("bp_valid",  32'(bus.victim_valid_out),   32'd1);
        bus.victim_ready_in = 1'b1;
        idle_count(5, pulses);
        check_eq("bp_drain_pulses", 32'(pulses), 32'd1);
        check_eq("bp_drain_active", 32'(bus.active_waymask_out), 32'h3);
        check_eq("bp_drain_valid",  32'(bus.victim_valid_out),   32'd0);
        miss_one("m0011", 1);
        bus.miss_valid_in = 1'b0;
        tick();

        // Alternating suggestion never settles
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            bus.suggested_waymask_in = (i % 2 == 0) ? 4'b1100 : 4'b0011;
            tick();
            if (bus.mask_update_pulse_out === 1'b1) pulses++;
        end
        check_eq("alt_pulses", 32'(pulses), 32'd0);
        check_eq("alt_active", 32'(bus.active_waymask_out), 32'h3);

        // All-zero suggestion ignored, then single-bit 1000 adopted
        bus.suggested_waymask_in = 4'b0000;
        idle_count(8, pulses);
        check_eq("zero_pulses", 32'(pulses), 32'd0);
        check_eq("zero_active", 32'(bus.active_waymask_out), 32'h3);
        bus.suggested_waymask_in = 4'b1000;
        idle_count(8, pulses);
        check_eq("m1000_pulses", 32'(pulses), 32'd1);
        check_eq("m1000_active", 32'(bus.active_waymask_out), 32'h8);
        for (int i = 0; i < 3; i++) miss_one("m1000", 3);
        bus.miss_valid_in = 1'b0;
        tick();

        // Asynchronous reset with victim pending
        bus.victim_ready_in = 1'b0;
        miss_one("prerst", 3);
        bus.miss_valid_in = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid",  32'(bus.victim_valid_out),   32'd0);
        check_eq("arst_active", 32'(bus.active_waymask_out), 32'hf);
        check_eq("arst_way",    32'(bus.victim_way_out),     32'd0);
        check_eq("arst_index",  32'(bus.victim_index_out),   32'd0);
        bus.suggested_waymask_in = 4'b1111;
        bus.victim_ready_in      = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        miss_one("postrst", 0);
        bus.miss_valid_in = 1'b0;
        tick();
        check_eq("postrst_active", 32'(bus.active_waymask_out), 32'hf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
